clock_group_reset_seq: RTL and testbench
========================================

CLOCK_GROUP_RESET_SEQ -- requirements
Module: clock_group_reset_seq

Interface
REQ-001 SHALL have parameter NUM_MEMBERS, default 4, number of clock-group members (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, reset-deassertion synchronizer depth (2..4).
REQ-003 SHALL have parameter STAGGER, default 8, cycles between successive member releases and software-reset hold length (1..255).
REQ-004 SHALL have port clock  input  1  the single clock for all logic.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port sw_reset_req  input  1  single-cycle pulse requesting a group reset.
REQ-007 SHALL have port gate_req  input  NUM_MEMBERS  per-member level request to stop that member's clock.
REQ-008 SHALL have port out_reset  output  NUM_MEMBERS  per-member active-high reset.
REQ-009 SHALL have port out_clock_en  output  NUM_MEMBERS  per-member clock enable for an external gate cell.
REQ-010 SHALL have port gate_ack  output  NUM_MEMBERS  per-member acknowledge, high while that member is gated.
REQ-011 SHALL have port busy  output  1  high whenever state is not RUN.
REQ-012 SHALL have port state  output  2  encoded FSM state: ASSERT=0, RELEASE=1, RUN=2.

Function
REQ-013 SHALL implement a 3-state FSM: ASSERT, RELEASE, RUN; all outputs registered.
REQ-014 SHALL pass reset deassertion through a SYNC_STAGES-deep flop chain; assertion SHALL act asynchronously.
REQ-015 SHALL leave ASSERT after power-on once the synchronizer output deasserts, i.e. on the SYNC_STAGES-th rising edge after reset rises.
REQ-016 SHALL, in RELEASE, run a counter of width clog2(STAGGER+1) and a member index of width max(1,clog2(NUM_MEMBERS)); on each STAGGER-th cycle it clears out_reset[idx] and increments idx.
REQ-017 SHALL deassert out_reset[i] on rising edge SYNC_STAGES+(i+1)*STAGGER after power-on reset release; members release in ascending index order.
REQ-018 SHALL enter RUN on the same edge that clears out_reset[NUM_MEMBERS-1]; counter and idx SHALL clear on entry.
REQ-019 SHALL, on sw_reset_req in RUN, set all out_reset bits on the next edge, enter ASSERT, hold STAGGER cycles, then enter RELEASE.
REQ-020 SHALL, on sw_reset_req in RELEASE, set all out_reset bits, clear idx, and re-enter ASSERT (restart).
REQ-021 SHALL ignore sw_reset_req in ASSERT; the hold counter SHALL NOT restart.
REQ-022 SHALL, in RUN, clear out_clock_en[i] and set gate_ack[i] on the edge after gate_req[i] is sampled high; both SHALL revert on the edge after gate_req[i] is sampled low.
REQ-023 SHALL force out_clock_en to all-ones and gate_ack to all-zeros in ASSERT and RELEASE, so clocks run during reset.
REQ-024 SHALL give sw_reset_req priority over gate_req in the same cycle: all enables return high on the edge entering ASSERT.
REQ-025 SHALL keep out_reset[i] unchanged by gating.

Reset
REQ-026 SHALL, while reset is low, drive out_reset all-ones, out_clock_en all-ones, gate_ack all-zeros, busy=1, state=ASSERT, counter=0, idx=0.
REQ-027 SHALL, on reset assertion mid-RELEASE or mid-RUN, return immediately to REQ-026 values and repeat the full REQ-017 sequence after release.

Verification (NUM_MEMBERS=4, SYNC_STAGES=2, STAGGER=8)
REQ-028 Power-on: reset rises at edge 0 -> out_reset bits 0..3 clear at edges 10/18/26/34; state=RUN and busy=0 at edge 34.
REQ-029 Gating: in RUN, gate_req=4'b0101 for 5 cycles -> out_clock_en=4'b1010 and gate_ack=4'b0101 from the next edge for 5 cycles, then 4'b1111/4'b0000.
REQ-030 Software reset: pulse sw_reset_req in RUN at edge T -> out_reset=4'hF at T+1, RELEASE at T+9, member 0 released at T+17, RUN at T+41.
REQ-031 Restart: pulse sw_reset_req at edge 20 during power-on RELEASE -> out_reset=4'hF at edge 21, idx=0, release sequence restarts from ASSERT.
REQ-032 Priority: sw_reset_req and gate_req=4'hF together in RUN -> out_clock_en stays 4'hF, gate_ack stays 0, state=ASSERT.
REQ-033 Async reset mid-sequence: drop reset at edge 22 -> all outputs at REQ-026 values before the next edge; after release, timing matches REQ-028.

Source files
------------

// File: rtl/clock_group_reset_seq.sv
// -----------------------------------------------------------------------------
// clock_group_reset_seq
//
// Reset and clock-enable sequencer for a group of clock-domain members that
// share a single clock. After power-on (or a software reset request) every
// member is held in reset. Members then leave reset one at a time, in
// ascending index order, STAGGER cycles apart. Once all members are out of
// reset the group is in RUN. In RUN each member's clock can be stopped on
// request. In ASSERT and RELEASE all member clocks are kept running.
//
// Ports
//   clock         in   single clock for all logic
//   reset         in   asynchronous active-low reset; deassertion is
//                      synchronised by a SYNC_STAGES-deep chain
//   sw_reset_req  in   single-cycle pulse requesting a group reset
//   gate_req      in   [NUM_MEMBERS] level request to stop a member's clock
//   out_reset     out  [NUM_MEMBERS] active-high member resets
//   out_clock_en  out  [NUM_MEMBERS] member clock enables for external gates
//   gate_ack      out  [NUM_MEMBERS] high while the member is gated
//   busy          out  high whenever state is not RUN
//   state         out  [2] FSM state: ASSERT=0, RELEASE=1, RUN=2
// -----------------------------------------------------------------------------
module clock_group_reset_seq #(
  parameter int NUM_MEMBERS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STAGGER     = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic [NUM_MEMBERS-1:0] gate_req,
  output logic [NUM_MEMBERS-1:0] out_reset,
  output logic [NUM_MEMBERS-1:0] out_clock_en,
  output logic [NUM_MEMBERS-1:0] gate_ack,
  output logic                   busy,
  output logic [1:0]             state
);

  localparam int CNT_W = $clog2(STAGGER + 1);
  localparam int IDX_W = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MEMBERS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e                 state_q;
  logic                   busy_q;
  logic                   hold_q;       // ASSERT was entered by software reset
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_MEMBERS-1:0] out_reset_q;
  logic [NUM_MEMBERS-1:0] out_clock_en_q;
  logic [NUM_MEMBERS-1:0] gate_ack_q;

  // The synchroniser has SYNC_STAGES-1 dedicated flops; the state register
  // itself acts as the final stage, so ASSERT is left on the SYNC_STAGES-th
  // rising edge after reset rises.
  logic [SYNC_STAGES-2:0] sync_q;
  logic                   sync_done;

  assign sync_done = sync_q[SYNC_STAGES-2];

  // NOTE: every flop, including the synchroniser, is cleared by the async
  // reset so assertion takes effect immediately without waiting for a clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q         <= '0;
      state_q        <= ST_ASSERT;
      busy_q         <= 1'b1;
      hold_q         <= 1'b0;
      cnt_q          <= '0;
      idx_q          <= '0;
      out_reset_q    <= '1;
      out_clock_en_q <= '1;
      gate_ack_q     <= '0;
    end else begin
      sync_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
        sync_q[i] <= sync_q[i-1];
      end

      case (state_q)
        // All members held; clocks running. A software reset request is
        // ignored here so a pending hold is never restarted.
        ST_ASSERT: begin
          out_clock_en_q <= '1;
          gate_ack_q     <= '0;
          if (sync_done) begin
            if (!hold_q) begin
              state_q <= ST_RELEASE;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= ST_RELEASE;
              cnt_q   <= '0;
              hold_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        // Release one member every STAGGER cycles; a software reset request
        // restarts the whole sequence from ASSERT.
        ST_RELEASE: begin
          out_clock_en_q <= '1;
          gate_ack_q     <= '0;
          if (sw_reset_req) begin
            state_q     <= ST_ASSERT;
            out_reset_q <= '1;
            hold_q      <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
          end else if (cnt_q == CNT_LAST) begin
            out_reset_q[idx_q] <= 1'b0;
            cnt_q              <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b0;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Per-member gating; software reset wins over gating in the same
        // cycle so every clock is running again on entry to ASSERT.
        ST_RUN: begin
          if (sw_reset_req) begin
            state_q        <= ST_ASSERT;
            busy_q         <= 1'b1;
            hold_q         <= 1'b1;
            cnt_q          <= '0;
            idx_q          <= '0;
            out_reset_q    <= '1;
            out_clock_en_q <= '1;
            gate_ack_q     <= '0;
          end else begin
            out_clock_en_q <= ~gate_req;
            gate_ack_q     <= gate_req;
          end
        end

        default: begin
          state_q        <= ST_ASSERT;
          busy_q         <= 1'b1;
          hold_q         <= 1'b0;
          cnt_q          <= '0;
          idx_q          <= '0;
          out_reset_q    <= '1;
          out_clock_en_q <= '1;
          gate_ack_q     <= '0;
        end
      endcase
    end
  end

  assign out_reset    = out_reset_q;
  assign out_clock_en = out_clock_en_q;
  assign gate_ack     = gate_ack_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule

// File: tb/tb_clock_group_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_clock_group_reset_seq
//
// Directed bench for clock_group_reset_seq (4 members, 2 sync stages,
// stagger 8). Expected output snapshots are queued with the edge number they
// belong to; a checker process pops and compares them 1 ns after each edge.
// Asynchronous-reset effects are compared immediately, between edges.
// -----------------------------------------------------------------------------
module tb_clock_group_reset_seq;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int STG = 8;

  localparam logic [1:0] S_ASSERT  = 2'd0;
  localparam logic [1:0] S_RELEASE = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;

  typedef struct packed {
    logic [N-1:0] rst;
    logic [N-1:0] en;
    logic [N-1:0] ack;
    logic         busy;
    logic [1:0]   st;
  } obs_t;

  typedef struct {
    int unsigned at;
    string       tag;
    obs_t        exp;
  } sb_t;

  logic         clock;
  logic         reset;
  logic         sw_reset_req;
  logic [N-1:0] gate_req;
  logic [N-1:0] out_reset;
  logic [N-1:0] out_clock_en;
  logic [N-1:0] gate_ack;
  logic         busy;
  logic [1:0]   state;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  sb_t         q[$];

  clock_group_reset_seq #(
    .NUM_MEMBERS(N),
    .SYNC_STAGES(SS),
    .STAGGER    (STG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sw_reset_req(sw_reset_req),
    .gate_req    (gate_req),
    .out_reset   (out_reset),
    .out_clock_en(out_clock_en),
    .gate_ack    (gate_ack),
    .busy        (busy),
    .state       (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic obs_t observe();
    obs_t o;
    o.rst  = out_reset;
    o.en   = out_clock_en;
    o.ack  = gate_ack;
    o.busy = busy;
    o.st   = state;
    return o;
  endfunction

  // Release sequence model: r is the edge on which RELEASE is entered,
  // member i leaves reset at r+(i+1)*STG, RUN is entered at r+N*STG.
  function automatic obs_t exp_seq(int e, int r);
    obs_t o;
    o.en  = '1;
    o.ack = '0;
    for (int i = 0; i < N; i++) o.rst[i] = (e < r + (i + 1) * STG);
    if (e < r)                o.st = S_ASSERT;
    else if (e < r + N * STG) o.st = S_RELEASE;
    else                      o.st = S_RUN;
    o.busy = (o.st != S_RUN);
    return o;
  endfunction

  function automatic obs_t exp_run(logic [N-1:0] gated);
    obs_t o;
    o.rst  = '0;
    o.en   = ~gated;
    o.ack  = gated;
    o.busy = 1'b0;
    o.st   = S_RUN;
    return o;
  endfunction

  function automatic obs_t exp_reset();
    obs_t o;
    o.rst  = '1;
    o.en   = '1;
    o.ack  = '0;
    o.busy = 1'b1;
    o.st   = S_ASSERT;
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t exp);
    obs_t got;
    got = observe();
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed rst=%b en=%b ack=%b busy=%b st=%0d, expected rst=%b en=%b ack=%b busy=%b st=%0d",
             tag, got.rst, got.en, got.ack, got.busy, got.st,
             exp.rst, exp.en, exp.ack, exp.busy, exp.st);
    end
  endtask

  task automatic push(input int unsigned at, input string tag, input obs_t exp);
    sb_t e;
    e.at  = at;
    e.tag = tag;
    e.exp = exp;
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Scoreboard checker: compare every entry due on this edge.
  always begin
    @(posedge clock);
    #1;
    while (q.size() > 0 && q[0].at <= cyc) begin
      sb_t e;
      e = q.pop_front();
      if (e.at < cyc) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed no check at edge %0d, expected one", e.tag, e.at);
      end else begin
        compare(e.tag, e.exp);
      end
    end
  end

  initial begin
    int unsigned base;
    int          por_edges[$];

    por_edges = '{1, 2, 9, 10, 17, 18, 25, 26, 33, 34, 35};

    reset        = 1'b1;
    sw_reset_req = 1'b0;
    gate_req     = '0;
    #1 reset = 1'b0;
    #1 compare("reset_low", exp_reset());
    tick(3);
    compare("reset_held", exp_reset());

    // Power-on release.
    base = cyc;
    reset = 1'b1;
    foreach (por_edges[k])
      push(base + por_edges[k], $sformatf("por_e%0d", por_edges[k]), exp_seq(por_edges[k], SS));
    tick(40);

    // Gating: 4'b0101 held for five sampled edges.
    base = cyc;
    gate_req = 4'b0101;
    for (int k = 1; k <= 5; k++) push(base + k, $sformatf("gate5_e%0d", k), exp_run(4'b0101));
    push(base + 6, "gate5_off", exp_run(4'b0000));
    tick(5);
    gate_req = '0;
    tick(2);

    // Single-cycle gating of the top member, then a two-member pattern.
    base = cyc;
    gate_req = 4'b1000;
    push(base + 1, "gate_msb_on", exp_run(4'b1000));
    push(base + 2, "gate_low2_on", exp_run(4'b0011));
    push(base + 3, "gate_low2_hold", exp_run(4'b0011));
    push(base + 4, "gate_low2_off", exp_run(4'b0000));
    tick(1);
    gate_req = 4'b0011;
    tick(2);
    gate_req = '0;
    tick(2);

    // Software reset in RUN at edge T; a second pulse during the hold is ignored.
    base = cyc;
    sw_reset_req = 1'b1;
    push(base + 1,  "swr_t1",  exp_seq(1, 9));
    push(base + 6,  "swr_t6",  exp_seq(6, 9));
    push(base + 8,  "swr_t8",  exp_seq(8, 9));
    push(base + 9,  "swr_t9",  exp_seq(9, 9));
    push(base + 16, "swr_t16", exp_seq(16, 9));
    push(base + 17, "swr_t17", exp_seq(17, 9));
    push(base + 33, "swr_t33", exp_seq(33, 9));
    push(base + 40, "swr_t40", exp_seq(40, 9));
    push(base + 41, "swr_t41", exp_seq(41, 9));
    tick(1);
    sw_reset_req = 1'b0;
    tick(3);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(40);

    // Priority: software reset together with full gating in RUN.
    base = cyc;
    sw_reset_req = 1'b1;
    gate_req     = 4'hF;
    push(base + 1,  "prio_t1",  exp_seq(1, 9));
    push(base + 3,  "prio_t3",  exp_seq(3, 9));
    push(base + 9,  "prio_t9",  exp_seq(9, 9));
    push(base + 41, "prio_t41", exp_seq(41, 9));
    tick(1);
    sw_reset_req = 1'b0;
    tick(3);
    gate_req = '0;
    tick(42);

    // Async reset while in RUN.
    reset = 1'b0;
    #1 compare("async_in_run", exp_reset());
    tick(2);

    // Restart: software reset pulse at edge 20 of the power-on release.
    base = cyc;
    reset = 1'b1;
    push(base + 10, "rst_e10", exp_seq(10, SS));
    push(base + 18, "rst_e18", exp_seq(18, SS));
    push(base + 20, "rst_e20", exp_seq(20, SS));
    push(base + 21, "rst_e21", exp_seq(21, 29));
    push(base + 28, "rst_e28", exp_seq(28, 29));
    push(base + 29, "rst_e29", exp_seq(29, 29));
    push(base + 37, "rst_e37", exp_seq(37, 29));
    push(base + 61, "rst_e61", exp_seq(61, 29));
    tick(20);
    sw_reset_req = 1'b1;
    tick(1);
    sw_reset_req = 1'b0;
    tick(45);

    // Async reset at edge 22 of a power-on release, then a full re-release.
    reset = 1'b0;
    tick(2);
    base = cyc;
    reset = 1'b1;
    push(base + 2,  "mid_e2",  exp_seq(2, SS));
    push(base + 10, "mid_e10", exp_seq(10, SS));
    push(base + 18, "mid_e18", exp_seq(18, SS));
    push(base + 22, "mid_e22", exp_seq(22, SS));
    tick(22);
    reset = 1'b0;
    #1 compare("async_mid_release", exp_reset());
    tick(2);
    base = cyc;
    reset = 1'b1;
    foreach (por_edges[k])
      push(base + por_edges[k], $sformatf("repor_e%0d", por_edges[k]), exp_seq(por_edges[k], SS));
    tick(40);

    tick(3);
    while (q.size() > 0) begin
      sb_t e;
      e = q.pop_front();
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed unserviced entry for edge %0d, expected serviced", e.tag, e.at);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
